// File: rtl/d5m_pkg.sv
// Shared definitions for the D5M sensor emulator: state encoding, default
// frame geometry (matches the 800x480 capture controller) and pixel width.
package d5m_pkg;

  localparam int D5M_PIX_W = 8;
  localparam int D5M_COLS  = 800;
  localparam int D5M_LINES = 480;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VBLANK = 3'd1,
    ST_FOT    = 3'd2,
    ST_LINE   = 3'd3,
    ST_HBLANK = 3'd4
  } d5m_state_t;

endpackage

// File: rtl/d5m_timing_gen.sv
// D5M frame timing generator: frame state machine, blanking/column/row
// counters and registered frame_valid/line_valid.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | stopped, waiting for enable
// ST_VBLANK | frame_valid low; VBLANK cycles minimum, then wait start_ok
// ST_FOT    | frame_valid high, FOT cycles before the first line
// ST_LINE   | one pixel slot per cycle, COLS cycles
// ST_HBLANK | line_valid low between lines, HBLANK cycles
module d5m_timing_gen
  import d5m_pkg::*;
#(
  parameter int COLS   = D5M_COLS,
  parameter int LINES  = D5M_LINES,
  parameter int HBLANK = 16,
  parameter int VBLANK = 64,
  parameter int FOT    = 8,
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int RW    = (LINES > 1) ? $clog2(LINES) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          start_ok,
  output logic          vblank_slot,
  output logic          frame_start,
  output logic          pixel_slot,
  output logic          first_pixel,
  output logic          last_pixel,
  output logic [CW-1:0] col_cnt,
  output logic [RW-1:0] row_cnt,
  output logic          frame_valid,
  output logic          line_valid,
  output logic          busy
);

  if (COLS < 1 || LINES < 1 ||
      HBLANK < 1 || HBLANK > 65535 ||
      VBLANK < 1 || VBLANK > 65535 ||
      FOT < 1 || FOT > 65535) begin : g_bad_param
    $error("d5m_timing_gen: geometry/blanking parameter out of range");
  end

  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(LINES - 1);
  localparam logic [15:0]   VB_LOAD  = 16'(VBLANK - 1);
  localparam logic [15:0]   FOT_LOAD = 16'(FOT - 1);
  localparam logic [15:0]   HB_LOAD  = 16'(HBLANK - 1);

  d5m_state_t  state, state_nxt;
  logic [15:0] blank_cnt;
  logic        line_end, frame_end, blank_done;
  logic        fv_nxt, lv_nxt;

  assign blank_done = (blank_cnt == 16'd0);
  assign line_end   = (state == ST_LINE) && (col_cnt == COL_LAST);
  assign frame_end  = line_end && (row_cnt == ROW_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; enable only matters at frame boundaries
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (enable) state_nxt = ST_VBLANK;
      ST_VBLANK: if (blank_done && start_ok) state_nxt = ST_FOT;
      ST_FOT:    if (blank_done) state_nxt = ST_LINE;
      ST_LINE: begin
        if (frame_end)     state_nxt = enable ? ST_VBLANK : ST_IDLE;
        else if (line_end) state_nxt = ST_HBLANK;
      end
      ST_HBLANK: if (blank_done) state_nxt = ST_LINE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Decoded state outputs and next values of the sensor strobes
  always_comb begin
    busy        = (state != ST_IDLE);
    vblank_slot = (state == ST_VBLANK);
    pixel_slot  = (state == ST_LINE);
    frame_start = (state == ST_VBLANK) && (state_nxt == ST_FOT);
    first_pixel = pixel_slot && (col_cnt == '0) && (row_cnt == '0);
    last_pixel  = frame_end;
    fv_nxt      = (state == ST_FOT) || (state == ST_LINE) || (state == ST_HBLANK);
    lv_nxt      = pixel_slot;
  end

  // Blanking down-counter reloads on state entry; column/row track the pixel slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_cnt <= '0;
      col_cnt   <= '0;
      row_cnt   <= '0;
    end else begin
      if (state_nxt != state) begin
        case (state_nxt)
          ST_VBLANK: blank_cnt <= VB_LOAD;
          ST_FOT:    blank_cnt <= FOT_LOAD;
          ST_HBLANK: blank_cnt <= HB_LOAD;
          default:   blank_cnt <= '0;
        endcase
      end else if (!blank_done) begin
        blank_cnt <= blank_cnt - 16'd1;
      end

      if (state == ST_LINE)
        col_cnt <= (col_cnt == COL_LAST) ? '0 : col_cnt + 1'b1;

      if (line_end)
        row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
      else if ((state == ST_IDLE) || (state == ST_VBLANK))
        row_cnt <= '0;
    end
  end

  // Sensor FVAL/LVAL, one cycle behind the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid <= 1'b0;
      line_valid  <= 1'b0;
    end else begin
      frame_valid <= fv_nxt;
      line_valid  <= lv_nxt;
    end
  end

endmodule

// File: rtl/d5m_sensor_emu.sv
// D5M sensor emulator top: turns an 8-bit Avalon-ST pixel stream into D5M
// parallel timing. Handles the stream handshake, pixel mux and sticky flags.
// Optional build macro D5M_EMU_PATTERN_EN adds an internal (row+col) test
// pattern selected per frame by pattern_sel.
module d5m_sensor_emu
  import d5m_pkg::*;
#(
  parameter int          COLS       = D5M_COLS,
  parameter int          LINES      = D5M_LINES,
  parameter int          HBLANK     = 16,
  parameter int          VBLANK     = 64,
  parameter int          FOT        = 8,
  parameter logic [7:0]  FILL_VALUE = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] snk_data,
  input  logic       snk_valid,
  input  logic       snk_startofpacket,
  input  logic       snk_endofpacket,
  output logic       snk_ready,
  output logic       frame_valid,
  output logic       line_valid,
  output logic [7:0] data_out,
  output logic       busy,
  input  logic       clear_err,
  output logic       underrun,
  output logic       sync_err,
  input  logic       pattern_sel
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (LINES > 1) ? $clog2(LINES) : 1;

  logic          vblank_slot, frame_start, pixel_slot, first_pixel, last_pixel;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic          start_ok, sink_off, chk_en;
  logic          underrun_set, sync_set;
  logic [D5M_PIX_W-1:0] pix_nxt;

  d5m_timing_gen #(
    .COLS   (COLS),
    .LINES  (LINES),
    .HBLANK (HBLANK),
    .VBLANK (VBLANK),
    .FOT    (FOT)
  ) u_timing (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .start_ok    (start_ok),
    .vblank_slot (vblank_slot),
    .frame_start (frame_start),
    .pixel_slot  (pixel_slot),
    .first_pixel (first_pixel),
    .last_pixel  (last_pixel),
    .col_cnt     (col_cnt),
    .row_cnt     (row_cnt),
    .frame_valid (frame_valid),
    .line_valid  (line_valid),
    .busy        (busy)
  );

`ifdef D5M_EMU_PATTERN_EN
  logic       pat_mode;
  logic [7:0] pat_pix;

  // Pattern choice is frozen for the whole frame at VBLANK exit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           pat_mode <= 1'b0;
    else if (frame_start) pat_mode <= pattern_sel;
  end

  // In VBLANK the live pattern_sel decides whether to wait for a sop
  assign sink_off = vblank_slot ? pattern_sel : pat_mode;
  assign start_ok = pattern_sel | (snk_valid & snk_startofpacket);
  assign chk_en   = pixel_slot & ~pat_mode;
  assign pat_pix  = 8'(row_cnt) + 8'(col_cnt);
`else
  logic unused_pattern;
  assign unused_pattern = ^{pattern_sel, frame_start, row_cnt, col_cnt};
  assign sink_off = 1'b0;
  assign start_ok = snk_valid & snk_startofpacket;
  assign chk_en   = pixel_slot;
`endif

  // Handshake: drop stray beats in VBLANK, hold the sop, consume every line slot
  always_comb begin
    snk_ready = 1'b0;
    if (!sink_off) begin
      if (vblank_slot)     snk_ready = snk_valid & ~snk_startofpacket;
      else if (pixel_slot) snk_ready = snk_valid;
    end
  end

  // Pixel to launch next cycle; fill value on underrun and outside lines
  always_comb begin
    pix_nxt = FILL_VALUE;
    if (pixel_slot && snk_valid) pix_nxt = snk_data;
`ifdef D5M_EMU_PATTERN_EN
    if (pixel_slot && pat_mode) pix_nxt = pat_pix;
`endif
  end

  assign underrun_set = chk_en & ~snk_valid;
  assign sync_set     = chk_en & snk_valid &
                        ((snk_startofpacket & ~first_pixel) |
                         (snk_endofpacket ^ last_pixel));

  // Registered pixel bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_out <= '0;
    else        data_out <= pix_nxt;
  end

  // Sticky error flags; a new event wins over clear_err
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      if (underrun_set)   underrun <= 1'b1;
      else if (clear_err) underrun <= 1'b0;
      if (sync_set)       sync_err <= 1'b1;
      else if (clear_err) sync_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_d5m_sensor_emu.sv
// Directed bench for d5m_sensor_emu on a 4x3 frame. Expected pixels are
// queued when a frame is driven and popped on every line_valid cycle.
module tb_d5m_sensor_emu;

  localparam int         COLS   = 4;
  localparam int         LINES  = 3;
  localparam int         HBLANK = 2;
  localparam int         VBLANK = 3;
  localparam int         FOT    = 1;
  localparam logic [7:0] FILL   = 8'h5A;
  localparam int         FV_EXP = FOT + LINES * COLS + (LINES - 1) * HBLANK;
  localparam int         BOUND  = 200;

  logic       clk, rst_n, enable;
  logic [7:0] snk_data;
  logic       snk_valid, snk_startofpacket, snk_endofpacket, snk_ready;
  logic       frame_valid, line_valid, busy, clear_err, underrun, sync_err, pattern_sel;
  logic [7:0] data_out;

  int         n_vec  = 0;
  int         n_miss = 0;
  logic [7:0] exp_q[$];

  d5m_sensor_emu #(
    .COLS(COLS), .LINES(LINES), .HBLANK(HBLANK), .VBLANK(VBLANK), .FOT(FOT),
    .FILL_VALUE(FILL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .snk_data(snk_data), .snk_valid(snk_valid),
    .snk_startofpacket(snk_startofpacket), .snk_endofpacket(snk_endofpacket),
    .snk_ready(snk_ready), .frame_valid(frame_valid), .line_valid(line_valid),
    .data_out(data_out), .busy(busy), .clear_err(clear_err),
    .underrun(underrun), .sync_err(sync_err), .pattern_sel(pattern_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pixel scoreboard plus FOT / line / hblank / frame lengths
  int fv_cnt, fot_cnt, hb_cnt, lv_run;
  bit seen_lv, prev_fv, prev_lv;
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) begin
      fv_cnt = 0; fot_cnt = 0; hb_cnt = 0; lv_run = 0;
      seen_lv = 0; prev_fv = 0; prev_lv = 0;
    end else begin
      if (frame_valid) fv_cnt++;
      if (line_valid) begin
        if (!prev_lv) begin
          if (!seen_lv) check("fot_len", fot_cnt, FOT);
          else          check("hblank_len", hb_cnt, HBLANK);
          seen_lv = 1; hb_cnt = 0;
        end
        lv_run++;
        check("pixel_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("pixel_data", data_out, e);
        end
      end else begin
        if (prev_lv) begin
          check("line_len", lv_run, COLS);
          lv_run = 0;
        end
        if (frame_valid) begin
          if (seen_lv) hb_cnt++;
          else         fot_cnt++;
        end
      end
      if (prev_fv && !frame_valid) begin
        check("frame_len", fv_cnt, FV_EXP);
        fv_cnt = 0; fot_cnt = 0; hb_cnt = 0; seen_lv = 0;
      end
      prev_fv = frame_valid;
      prev_lv = line_valid;
    end
  end

  // Present one beat at a negedge and hold it until snk_ready; returns at a negedge
  task automatic send_beat(input logic [7:0] d, input logic sop, input logic eop, output bit ok);
    snk_data = d; snk_valid = 1'b1;
    snk_startofpacket = sop; snk_endofpacket = eop;
    ok = 0;
    for (int c = 0; c < BOUND; c++) begin
      #4;
      if (snk_ready) begin
        ok = 1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_frame(input logic [7:0] base, input int n, input int pre_drop,
                           input int gap_after, input int eop_at, input int dis_at);
    bit ok;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(base + 8'(k));
      if (k == gap_after) exp_q.push_back(FILL);
    end
    for (int i = 0; i < pre_drop; i++) begin
      send_beat(8'hE0 + 8'(i), 1'b0, 1'b0, ok);
      check("drop_accept", 32'(ok), 1);
    end
    for (int k = 0; k < n; k++) begin
      send_beat(base + 8'(k), k == 0, k == eop_at, ok);
      check("beat_accept", 32'(ok), 1);
      if (!ok) break;
      if (k == gap_after) begin
        snk_valid = 1'b0; snk_startofpacket = 1'b0; snk_endofpacket = 1'b0;
        @(negedge clk);
      end
      if (k == dis_at) enable = 1'b0;
    end
    snk_valid = 1'b0; snk_startofpacket = 1'b0; snk_endofpacket = 1'b0;
  endtask

  task automatic wait_frame_end(input string tag);
    for (int c = 0; c < BOUND && frame_valid; c++) @(negedge clk);
    check({tag, "_fv_end"}, 32'(frame_valid), 0);
    check({tag, "_queue_drained"}, 32'(exp_q.size()), 0);
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
  endtask

  initial begin
    int fv_hi;
    rst_n = 1'b0; enable = 1'b0; clear_err = 1'b0; pattern_sel = 1'b0;
    snk_data = 8'h00; snk_valid = 1'b0;
    snk_startofpacket = 1'b0; snk_endofpacket = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_frame_valid", 32'(frame_valid), 0);
    check("rst_line_valid", 32'(line_valid), 0);
    check("rst_data_out", 32'(data_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_snk_ready", 32'(snk_ready), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_sync_err", 32'(sync_err), 0);

    rst_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;

    // Clean frame
    run_frame(8'h10, 12, 0, -1, 11, -1);
    wait_frame_end("t1");
    check("t1_underrun", 32'(underrun), 0);
    check("t1_sync_err", 32'(sync_err), 0);

    // Two stray beats before the sop are dropped in VBLANK
    run_frame(8'h30, 12, 2, -1, 11, -1);
    wait_frame_end("t2");
    check("t2_underrun", 32'(underrun), 0);
    check("t2_sync_err", 32'(sync_err), 0);

    // Underrun at pixel (1,2), then clear
    run_frame(8'h50, 11, 0, 5, 10, -1);
    wait_frame_end("t3");
    check("t3_underrun", 32'(underrun), 1);
    check("t3_sync_err", 32'(sync_err), 0);
    pulse_clear();
    check("t3_underrun_cleared", 32'(underrun), 0);

    // Early eop on pixel 10 of 12
    run_frame(8'h70, 12, 0, -1, 9, -1);
    wait_frame_end("t4");
    check("t4_sync_err", 32'(sync_err), 1);
    check("t4_underrun", 32'(underrun), 0);
    pulse_clear();
    check("t4_sync_cleared", 32'(sync_err), 0);

    // enable dropped during line 1: frame completes then stays idle
    run_frame(8'h90, 12, 0, -1, 11, 6);
    wait_frame_end("t5a");
    check("t5a_busy", 32'(busy), 0);
    fv_hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (frame_valid || busy) fv_hi++;
    end
    check("t5a_stays_idle", fv_hi, 0);

    // Reset in the middle of line 1
    enable = 1'b1;
    run_frame(8'hB0, 6, 0, -1, -1, -1);
    #2 rst_n = 1'b0;
    #1;
    check("t5b_frame_valid", 32'(frame_valid), 0);
    check("t5b_line_valid", 32'(line_valid), 0);
    check("t5b_data_out", 32'(data_out), 0);
    check("t5b_busy", 32'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    check("t5b_queue_drained", 32'(exp_q.size()), 0);
    rst_n = 1'b1;

    // Restart after reset
    run_frame(8'hC0, 12, 0, -1, 11, -1);
    wait_frame_end("t5c");
    check("t5c_underrun", 32'(underrun), 0);
    check("t5c_sync_err", 32'(sync_err), 0);

`ifdef D5M_EMU_PATTERN_EN
    begin
      int rdy_hi;
      bit seen;
      for (int r = 0; r < LINES; r++)
        for (int c = 0; c < COLS; c++)
          exp_q.push_back(8'(r + c));
      pattern_sel = 1'b1;
      rdy_hi = 0; seen = 0;
      for (int c = 0; c < BOUND; c++) begin
        @(negedge clk);
        if (snk_ready) rdy_hi++;
        if (frame_valid) seen = 1;
        if (seen && !frame_valid) break;
      end
      pattern_sel = 1'b0;
      check("t6_frame_seen", 32'(seen), 1);
      check("t6_snk_ready_low", rdy_hi, 0);
      check("t6_queue_drained", 32'(exp_q.size()), 0);
      check("t6_underrun", 32'(underrun), 0);
      check("t6_sync_err", 32'(sync_err), 0);
    end
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion, expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

endmodule
